// File: rtl/button_pio_event_sequencer.sv
// Avalon-MM master that services the 2-bit button PIO and queues timestamped events in a FWFT FIFO.
// An irq seen in IDLE at cycle N reaches PUSH at N+6. Consumer backpressure via evt_ready; pushes into a full FIFO are counted and dropped.
module button_pio_event_sequencer #(
  parameter int TS_W       = 24,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic [1:0]       pio_address,
  output logic             pio_chipselect,
  output logic             pio_write_n,
  output logic [31:0]      pio_writedata,
  input  logic [31:0]      pio_readdata,
  input  logic             pio_irq,
  input  logic [1:0]       cfg_mask,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [TS_W+3:0]  evt_data,
  output logic [7:0]       drop_count,
  output logic             busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = TS_W + 4;

  typedef enum logic [2:0] {
    S_CFG      = 3'd0,
    S_IDLE     = 3'd1,
    S_RD_CAP_A = 3'd2,
    S_RD_CAP_S = 3'd3,
    S_CLR      = 3'd4,
    S_RD_DAT_A = 3'd5,
    S_RD_DAT_S = 3'd6,
    S_PUSH     = 3'd7
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      mask_shadow_q, mask_shadow_d;
  logic [TS_W-1:0] ts_q, ts_d;
  logic [TS_W-1:0] ts_cap_q, ts_cap_d;
  logic [1:0]      edges_q, edges_d;
  logic [1:0]      level_q, level_d;
  logic [1:0]      addr_q, addr_d;
  logic            cs_q, cs_d;
  logic            wn_q, wn_d;
  logic [1:0]      wd_q, wd_d;
  logic            busy_q, busy_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [7:0]      drop_q, drop_d;
  logic [EW-1:0]   mem_q [FIFO_DEPTH];

  logic push_req, do_push, pop, drop, full, empty;
  logic unused_rd;

  assign unused_rd = ^pio_readdata[31:2];

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  always_comb begin
    state_d       = state_q;
    mask_shadow_d = mask_shadow_q;
    ts_d          = ts_q + TS_W'(1);
    ts_cap_d      = ts_cap_q;
    edges_d       = edges_q;
    level_d       = level_q;
    push_req      = 1'b0;

    case (state_q)
      // After reset the bus is still idle, so CFG holds until its write is actually on the bus.
      S_CFG: begin
        if (cs_q && !wn_q) begin
          mask_shadow_d = wd_q;
          state_d       = S_IDLE;
        end
      end
      S_IDLE: begin
        if (cfg_mask != mask_shadow_q) begin
          state_d = S_CFG;
        end else if (pio_irq) begin
          ts_cap_d = ts_q;
          state_d  = S_RD_CAP_A;
        end
      end
      S_RD_CAP_A: state_d = S_RD_CAP_S;
      S_RD_CAP_S: begin
        edges_d = pio_readdata[1:0];
        state_d = S_CLR;
      end
      S_CLR:      state_d = S_RD_DAT_A;
      S_RD_DAT_A: state_d = S_RD_DAT_S;
      S_RD_DAT_S: begin
        level_d = pio_readdata[1:0];
        state_d = S_PUSH;
      end
      S_PUSH: begin
        push_req = |(edges_q & mask_shadow_q);
        state_d  = S_IDLE;
      end
      default: state_d = S_CFG;
    endcase

    // Bus outputs are registered from the state being entered, so they line up with state_q.
    cs_d   = 1'b0;
    wn_d   = 1'b1;
    addr_d = 2'd0;
    wd_d   = 2'd0;
    case (state_d)
      S_CFG: begin
        cs_d   = 1'b1;
        wn_d   = 1'b0;
        addr_d = 2'd2;
        wd_d   = cfg_mask;
      end
      S_RD_CAP_A, S_RD_CAP_S: begin
        cs_d   = 1'b1;
        addr_d = 2'd3;
      end
      S_CLR: begin
        cs_d   = 1'b1;
        wn_d   = 1'b0;
        addr_d = 2'd3;
      end
      S_RD_DAT_A, S_RD_DAT_S: begin
        cs_d   = 1'b1;
        addr_d = 2'd0;
      end
      default: begin
        cs_d   = 1'b0;
        wn_d   = 1'b1;
      end
    endcase
    busy_d = (state_d != S_IDLE);

    pop      = !empty && evt_ready;
    do_push  = push_req && (!full || pop);
    drop     = push_req && full && !pop;
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    drop_d   = drop_q;
    if (drop && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_CFG;
      mask_shadow_q <= 2'd0;
      ts_q          <= '0;
      ts_cap_q      <= '0;
      edges_q       <= 2'd0;
      level_q       <= 2'd0;
      addr_q        <= 2'd0;
      cs_q          <= 1'b0;
      wn_q          <= 1'b1;
      wd_q          <= 2'd0;
      busy_q        <= 1'b1;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      drop_q        <= 8'd0;
    end else begin
      state_q       <= state_d;
      mask_shadow_q <= mask_shadow_d;
      ts_q          <= ts_d;
      ts_cap_q      <= ts_cap_d;
      edges_q       <= edges_d;
      level_q       <= level_d;
      addr_q        <= addr_d;
      cs_q          <= cs_d;
      wn_q          <= wn_d;
      wd_q          <= wd_d;
      busy_q        <= busy_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      drop_q        <= drop_d;
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {ts_cap_q, level_q, edges_q};
    end
  end

  assign pio_address    = addr_q;
  assign pio_chipselect = cs_q;
  assign pio_write_n    = wn_q;
  assign pio_writedata  = {30'd0, wd_q};
  assign evt_valid      = !empty;
  assign evt_data       = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign drop_count     = drop_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_button_pio_event_sequencer.sv
// Bench for button_pio_event_sequencer: behavioural PIO slave, write and event scoreboards, directed scenarios.
`timescale 1ns/1ps
module tb_button_pio_event_sequencer;
  localparam int TS_W  = 24;
  localparam int DEPTH = 8;
  localparam int EW    = TS_W + 4;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [1:0]      pio_address;
  logic            pio_chipselect;
  logic            pio_write_n;
  logic [31:0]     pio_writedata;
  logic [31:0]     pio_readdata;
  logic            pio_irq;
  logic [1:0]      cfg_mask;
  logic            evt_valid;
  logic            evt_ready;
  logic [EW-1:0]   evt_data;
  logic [7:0]      drop_count;
  logic            busy;

  always #5 clk = ~clk;

  button_pio_event_sequencer #(.TS_W(TS_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .pio_address(pio_address), .pio_chipselect(pio_chipselect),
    .pio_write_n(pio_write_n), .pio_writedata(pio_writedata),
    .pio_readdata(pio_readdata), .pio_irq(pio_irq), .cfg_mask(cfg_mask),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_data(evt_data),
    .drop_count(drop_count), .busy(busy)
  );

  // PIO slave model: registered readdata, write to edge_capture clears it, irq from pending edges.
  logic [1:0]  pio_mask_m, pio_edge_m, btn, inj;
  logic [31:0] rd_m;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pio_mask_m <= 2'd0;
      pio_edge_m <= 2'd0;
      rd_m       <= 32'd0;
    end else begin
      case (pio_address)
        2'd0:    rd_m <= {30'd0, btn};
        2'd2:    rd_m <= {30'd0, pio_mask_m};
        2'd3:    rd_m <= {30'd0, pio_edge_m};
        default: rd_m <= 32'd0;
      endcase
      if (pio_chipselect && !pio_write_n && pio_address == 2'd2) pio_mask_m <= pio_writedata[1:0];
      if (pio_chipselect && !pio_write_n && pio_address == 2'd3) pio_edge_m <= 2'd0;
      else pio_edge_m <= pio_edge_m | inj;
    end
  end
  assign pio_readdata = rd_m;
  assign pio_irq      = |pio_edge_m;

  logic [TS_W-1:0] tb_ts;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) tb_ts <= '0;
    else          tb_ts <= tb_ts + 24'd1;
  end

  int checks = 0;
  int failures = 0;
  logic [33:0]   wq[$];
  logic [EW-1:0] eq[$];
  logic [1:0]    shadow_exp;
  int            drop_exp;
  logic [3:0]    tr_exp [1:6] = '{4'b1111, 4'b1111, 4'b1011, 4'b1100, 4'b1100, 4'b0100};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Monitor: every bus write and every event handshake is checked against the scoreboards.
  initial begin
    logic [33:0]   w;
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (reset_n && pio_chipselect && !pio_write_n) begin
        if (wq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_write addr=%0d data=%0h", pio_address, pio_writedata);
        end else begin
          w = wq.pop_front();
          chk("bus_write", 64'({pio_address, pio_writedata}), 64'(w));
        end
      end
      if (evt_valid && evt_ready) begin
        if (eq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_event data=%0h", evt_data);
        end else begin
          e = eq.pop_front();
          chk("evt_data", 64'(evt_data), 64'(e));
        end
      end
    end
  end

  task automatic set_mask(input logic [1:0] m);
    @(negedge clk);
    cfg_mask = m;
    shadow_exp = m;
    wq.push_back({2'd2, 30'd0, m});
    repeat (3) @(negedge clk);
  endtask

  // One irq service; optional pop in the PUSH cycle and optional cfg_mask change mid-sequence.
  task automatic service(input logic [1:0] e, input logic [1:0] lvl, input bit simul_pop,
                         input int chg_at, input logic [1:0] new_mask);
    logic [TS_W-1:0] t;
    @(negedge clk);
    btn = lvl;
    inj = e;
    @(negedge clk);
    inj = 2'd0;
    t = tb_ts;
    wq.push_back({2'd3, 32'd0});
    if ((e & shadow_exp) != 2'd0) begin
      if (eq.size() < DEPTH || simul_pop) eq.push_back({t, lvl, e});
      else drop_exp++;
    end
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (i == chg_at) begin
        cfg_mask = new_mask;
        shadow_exp = new_mask;
        wq.push_back({2'd2, 30'd0, new_mask});
      end
      if (simul_pop) evt_ready = (i == 6);
    end
  endtask

  initial begin
    cfg_mask = 2'b11; evt_ready = 1'b0; btn = 2'd0; inj = 2'd0;
    shadow_exp = 2'd0; drop_exp = 0;
    #12;
    chk("rst_cs", 64'(pio_chipselect), 64'(0));
    chk("rst_wn", 64'(pio_write_n), 64'(1));
    chk("rst_addr", 64'(pio_address), 64'(0));
    chk("rst_wd", 64'(pio_writedata), 64'(0));
    chk("rst_valid", 64'(evt_valid), 64'(0));
    chk("rst_data", 64'(evt_data), 64'(0));
    chk("rst_drop", 64'(drop_count), 64'(0));
    chk("rst_busy", 64'(busy), 64'(1));

    @(negedge clk);
    wq.push_back({2'd2, 32'd3});
    shadow_exp = 2'b11;
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_busy", 64'(busy), 64'(0));
    chk("idle_valid", 64'(evt_valid), 64'(0));
    chk("pio_mask_cfg", 64'(pio_mask_m), 64'(3));

    // Event captured at ts = 100, full bus trace and 7-cycle latency.
    evt_ready = 1'b1;
    btn = 2'b01;
    while (tb_ts != 24'd99) @(negedge clk);
    inj = 2'b01;
    @(negedge clk);
    inj = 2'd0;
    wq.push_back({2'd3, 32'd0});
    eq.push_back({24'd100, 2'b01, 2'b01});
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("trace_%0d", i),
          64'({pio_chipselect, pio_write_n, (pio_chipselect ? pio_address : 2'b00)}), 64'(tr_exp[i]));
    end
    chk("valid_before_push", 64'(evt_valid), 64'(0));
    @(negedge clk);
    #1;
    chk("valid_latency", 64'(evt_valid), 64'(1));
    repeat (3) @(negedge clk);

    // Spurious event: edge outside mask still cleared, nothing pushed.
    set_mask(2'b10);
    service(2'b01, 2'b00, 1'b0, 0, 2'b00);
    chk("spurious_valid", 64'(evt_valid), 64'(0));
    chk("spurious_drop", 64'(drop_count), 64'(0));

    // Overflow: 10 services into 8 entries, then full with simultaneous push and pop.
    set_mask(2'b11);
    evt_ready = 1'b0;
    for (int i = 0; i < 10; i++) service(2'((i % 3) + 1), 2'(i % 4), 1'b0, 0, 2'b00);
    chk("drop_after_overflow", 64'(drop_count), 64'(drop_exp));
    chk("drop_is_two", 64'(drop_count), 64'(2));
    chk("full_valid", 64'(evt_valid), 64'(1));
    service(2'b11, 2'b10, 1'b1, 0, 2'b00);
    chk("drop_after_simul", 64'(drop_count), 64'(2));
    evt_ready = 1'b1;
    for (int i = 0; i < 40 && eq.size() > 0; i++) @(negedge clk);
    if (eq.size() > 0) begin
      checks++; failures++;
      $display("FAIL drain_timeout remaining=%0d required=0", eq.size());
    end
    @(negedge clk);
    chk("drained_valid", 64'(evt_valid), 64'(0));

    // cfg_mask change during RD_CAP_S: old mask governs this push, CFG follows.
    set_mask(2'b01);
    service(2'b10, 2'b11, 1'b0, 2, 2'b11);
    chk("pio_mask_update", 64'(pio_mask_m), 64'(3));
    service(2'b10, 2'b10, 1'b0, 0, 2'b00);

    // Reset in RD_DAT_A with three entries queued.
    evt_ready = 1'b0;
    for (int i = 0; i < 3; i++) service(2'b01, 2'b01, 1'b0, 0, 2'b00);
    @(negedge clk);
    inj = 2'b01;
    @(negedge clk);
    inj = 2'd0;
    wq.push_back({2'd3, 32'd0});
    repeat (4) @(negedge clk);
    chk("pre_reset_valid", 64'(evt_valid), 64'(1));
    reset_n = 1'b0;
    #1;
    chk("midrst_cs", 64'(pio_chipselect), 64'(0));
    chk("midrst_wn", 64'(pio_write_n), 64'(1));
    chk("midrst_valid", 64'(evt_valid), 64'(0));
    chk("midrst_drop", 64'(drop_count), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(1));
    eq.delete();
    drop_exp = 0;
    wq.push_back({2'd2, 32'd3});
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_busy", 64'(busy), 64'(0));
    chk("post_rst_mask", 64'(pio_mask_m), 64'(3));
    evt_ready = 1'b1;
    service(2'b01, 2'b10, 1'b0, 0, 2'b00);
    repeat (3) @(negedge clk);

    chk("writes_left", 64'(wq.size()), 64'(0));
    chk("events_left", 64'(eq.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/button_pio_event_sequencer.md
Name: button_pio_event_sequencer

Overview:
Avalon-MM master that owns the 2-bit button PIO slave (registers: 0 = data, 2 = irq_mask, 3 = edge_capture) and services it in hardware.
- Programs the PIO irq mask.
- On PIO irq, reads and clears edge_capture, reads the live button level, and pushes a timestamped event record into an internal FIFO.
- A consumer drains the FIFO with valid/ready, so the CPU no longer takes an interrupt per button press.

Parameters:
TS_W, 24, width of free-running cycle timestamp (wraps modulo 2^TS_W)
FIFO_DEPTH, 8, event FIFO entries; power of 2, minimum 2

Ports:
clk  in  1  clock
reset_n  in  1  reset
pio_address  out  2  PIO register address
pio_chipselect  out  1  PIO chipselect
pio_write_n  out  1  PIO write strobe, active-low
pio_writedata  out  32  PIO write data
pio_readdata  in  32  PIO read data; registered in PIO, reflects the address presented one cycle earlier
pio_irq  in  1  PIO interrupt, level
cfg_mask  in  2  desired PIO irq mask, quasi-static
evt_valid  out  1  FIFO head valid
evt_ready  in  1  consumer accepts head
evt_data  out  TS_W+4  {timestamp, level[1:0], edges[1:0]}
drop_count  out  8  events lost to FIFO full; saturates at 255
busy  out  1  FSM not in IDLE

Behaviour:
- Reset: reset_n asynchronous, active-low; clock clk.
  - Values on reset: state CFG, mask_shadow = 0, ts = 0, FIFO empty, evt_valid = 0, evt_data = 0, drop_count = 0.
  - Bus outputs on reset: pio_address = 0, pio_chipselect = 0, pio_write_n = 1, pio_writedata = 0.
  - busy = 1 on reset (CFG).
- ts increments every cycle and wraps from 2^TS_W-1 to 0.
- FSM (one state per cycle):
  - CFG: drive cs = 1, write_n = 0, addr = 2, writedata = {30'b0, cfg_mask}; mask_shadow <= cfg_mask -> IDLE.
  - IDLE: bus idle (cs = 0, write_n = 1).
    - If cfg_mask != mask_shadow -> CFG. This has priority over irq.
    - Else if pio_irq: ts_cap <= ts -> RD_CAP_A.
  - RD_CAP_A: cs = 1, write_n = 1, addr = 3 -> RD_CAP_S.
  - RD_CAP_S: addr held at 3; edges <= pio_readdata[1:0] -> CLR.
  - CLR: cs = 1, write_n = 0, addr = 3, writedata = 0; this clears all PIO edge_capture bits -> RD_DAT_A.
  - RD_DAT_A: addr = 0, read -> RD_DAT_S.
  - RD_DAT_S: level <= pio_readdata[1:0] -> PUSH.
  - PUSH: push {ts_cap, level, edges} only if (edges & mask_shadow) != 0; spurious events are discarded -> IDLE.
- Writes use exactly one cycle of chipselect & ~write_n. No bus wait states are expected.
- Latency: pio_irq first seen high in IDLE at cycle N -> PUSH at N+6 -> evt_valid = 1 at N+7 (FIFO previously empty).
- Known loss window: an edge the PIO detects in the CLR cycle is lost, because the PIO's clear has priority. Accepted; not compensated.
- FIFO:
  - First-word-fall-through: evt_data = head whenever evt_valid = 1.
  - Pop when evt_valid & evt_ready.
  - Push when full with no simultaneous pop: record dropped, drop_count += 1, saturating at 255.
  - Full with simultaneous pop and push: both occur, nothing dropped.
  - Pop when empty: ignored.
- Stale irq: pio_irq falls one cycle after CLR, so it is already low on return to IDLE; no double service.
- cfg_mask change mid-sequence: the current sequence completes with the old mask_shadow, then IDLE takes CFG.
- Reset mid-sequence: everything returns to reset values, the FIFO is flushed, and CFG is re-entered (PIO mask rewritten).

Test Plan:
- Reset release with cfg_mask = 2'b11 -> first cycle: write addr 2, data 3; then IDLE, busy = 0, evt_valid = 0.
- PIO returns edge_capture = 2'b01, data = 2'b01; irq high in IDLE at ts = 100 -> bus sequence rd3, rd3, wr3 data 0, rd0, rd0; evt_valid rises 7 cycles later; evt_data = {100, 2'b01, 2'b01}.
- cfg_mask = 2'b10, edge_capture = 2'b01 -> clear write still issued; no push; evt_valid stays 0.
- evt_ready = 0, 10 irq services with FIFO_DEPTH = 8 -> 8 entries stored, drop_count = 2; then full with push and pop in the same cycle -> drop_count remains 2.
- cfg_mask changed 2'b01 -> 2'b11 during RD_CAP_S -> sequence finishes, then write addr 2 data 3 before the next irq service.
- reset_n asserted in RD_DAT_A with 3 entries queued -> bus idle, evt_valid = 0, drop_count = 0 immediately; CFG write after release.
